// File: rtl/sc_speedcounter_prescaled.sv
// Prescaled up/down speed counter with synchronous load, programmable terminal value,
// wrap or saturate at the bounds, and registered step/overflow/underflow pulses.
module sc_speedcounter_prescaled #(
    parameter int SPEEDCOUNTER_DATAWIDTH = 8,
    parameter int SPEEDCOUNTER_MAXVALUE  = 9,
    parameter int SPEEDCOUNTER_PRESCALE  = 4,
    parameter int SPEEDCOUNTER_WRAPMODE  = 1
) (
    input  logic                              SC_SPEEDCOUNTER_CLOCK_50,
    input  logic                              SC_SPEEDCOUNTER_RESET_InHigh,
    input  logic                              SC_SPEEDCOUNTER_upcount_InLow,
    input  logic                              SC_SPEEDCOUNTER_downcount_InLow,
    input  logic                              SC_SPEEDCOUNTER_load_InLow,
    input  logic [SPEEDCOUNTER_DATAWIDTH-1:0] SC_SPEEDCOUNTER_data_InBUS,
    output logic [SPEEDCOUNTER_DATAWIDTH-1:0] SC_SPEEDCOUNTER_data_OutBUS,
    output logic                              SC_SPEEDCOUNTER_max_OutHigh,
    output logic                              SC_SPEEDCOUNTER_min_OutHigh,
    output logic                              SC_SPEEDCOUNTER_tick_OutHigh,
    output logic                              SC_SPEEDCOUNTER_ovf_OutHigh,
    output logic                              SC_SPEEDCOUNTER_unf_OutHigh
);

    localparam int W    = SPEEDCOUNTER_DATAWIDTH;
    localparam int PS_W = (SPEEDCOUNTER_PRESCALE > 1) ? $clog2(SPEEDCOUNTER_PRESCALE) : 1;
    localparam logic [W-1:0]    MAX_V   = W'(SPEEDCOUNTER_MAXVALUE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SPEEDCOUNTER_PRESCALE - 1);
    localparam bit              WRAP    = (SPEEDCOUNTER_WRAPMODE != 0);

    logic [W-1:0]    count_p0;
    logic [PS_W-1:0] presc_p0;
    logic            tick_p0;
    logic            ovf_p0;
    logic            unf_p0;

    logic dir_valid;
    logic dir_up;
    logic presc_last;

    function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
        if (v < MAX_V)
            return v + W'(1);
        return WRAP ? '0 : MAX_V;
    endfunction

    function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
        if (v != '0)
            return v - W'(1);
        return WRAP ? MAX_V : '0;
    endfunction

    // Exactly one active-low request selects a direction; both or neither means idle.
    assign dir_valid  = SC_SPEEDCOUNTER_upcount_InLow ^ SC_SPEEDCOUNTER_downcount_InLow;
    assign dir_up     = ~SC_SPEEDCOUNTER_upcount_InLow;
    assign presc_last = (presc_p0 == PS_LAST);

    // Stage p0: prescaler, counter value and step pulses
    always_ff @(posedge SC_SPEEDCOUNTER_CLOCK_50) begin
        if (SC_SPEEDCOUNTER_RESET_InHigh) begin
            count_p0 <= '0;
            presc_p0 <= '0;
            tick_p0  <= 1'b0;
            ovf_p0   <= 1'b0;
            unf_p0   <= 1'b0;
        end else begin
            tick_p0 <= 1'b0;
            ovf_p0  <= 1'b0;
            unf_p0  <= 1'b0;
            if (!SC_SPEEDCOUNTER_load_InLow) begin
                count_p0 <= clamp_load(SC_SPEEDCOUNTER_data_InBUS);
                presc_p0 <= '0;
            end else if (dir_valid) begin
                if (presc_last) begin
                    presc_p0 <= '0;
                    tick_p0  <= 1'b1;
                    if (dir_up) begin
                        count_p0 <= step_up(count_p0);
                        ovf_p0   <= (count_p0 == MAX_V);
                    end else begin
                        count_p0 <= step_down(count_p0);
                        unf_p0   <= (count_p0 == '0);
                    end
                end else begin
                    presc_p0 <= presc_p0 + PS_W'(1);
                end
            end else begin
                presc_p0 <= '0;
            end
        end
    end

    assign SC_SPEEDCOUNTER_data_OutBUS  = count_p0;
    assign SC_SPEEDCOUNTER_max_OutHigh  = (count_p0 == MAX_V);
    assign SC_SPEEDCOUNTER_min_OutHigh  = (count_p0 == '0);
    assign SC_SPEEDCOUNTER_tick_OutHigh = tick_p0;
    assign SC_SPEEDCOUNTER_ovf_OutHigh  = ovf_p0;
    assign SC_SPEEDCOUNTER_unf_OutHigh  = unf_p0;

endmodule
